// File: rtl/array_frame_loader.sv
// Stream-to-array loader: assembles WIDTH-bit elements row-major into a double-buffered ROWS x COLS frame.
// Optional unpacked mirror output frame_unp when ARRAY_FRAME_LOADER_UNPACKED_EN is defined.
module array_frame_loader #(
  parameter int ROWS  = 4,
  parameter int COLS  = 2,
  parameter int WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      in_data,
  output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  frame_out,
  output logic                                  frame_valid,
  input  logic                                  frame_ack,
  output logic [$clog2(ROWS):0]                 row_idx,
  output logic [$clog2(COLS):0]                 col_idx,
  output logic [7:0]                            frame_count
`ifdef ARRAY_FRAME_LOADER_UNPACKED_EN
  ,
  output logic [WIDTH-1:0]                      frame_unp [ROWS-1:0][COLS-1:0]
`endif
);

  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] CLAST = CW'(COLS - 1);

  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] shadow, shadow_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic pending, pending_nxt;
  logic accept, last, publish_ok, xfer;

  assign in_ready   = !pending;
  assign accept     = in_valid && in_ready;
  assign last       = (row_idx == RLAST) && (col_idx == CLAST);
  assign publish_ok = !frame_valid || frame_ack;
  // A parked full shadow is published as soon as the consumer releases frame_out.
  assign xfer       = (accept && last && publish_ok) || (pending && frame_ack);

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < COLS; k++)
        if (accept && row_idx == RW'(i) && col_idx == CW'(k))
          shadow_nxt[i][k] = in_data;
  end

  always_comb begin
    row_nxt = row_idx;
    col_nxt = col_idx;
    if (accept) begin
      if (col_idx == CLAST) begin
        col_nxt = '0;
        row_nxt = (row_idx == RLAST) ? '0 : row_idx + RW'(1);
      end else begin
        col_nxt = col_idx + CW'(1);
      end
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (accept && last && !publish_ok) pending_nxt = 1'b1;
    else if (pending && frame_ack)     pending_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      pending     <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      row_idx <= row_nxt;
      col_idx <= col_nxt;
      pending <= pending_nxt;
      if (xfer) begin
        frame_out   <= shadow_nxt;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef ARRAY_FRAME_LOADER_UNPACKED_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < COLS; k++)
        if (rst)       frame_unp[i][k] <= '0;
        else if (xfer) frame_unp[i][k] <= shadow_nxt[i][k];
  end
`endif

endmodule

// File: tb/tb_array_frame_loader.sv
// Bench for array_frame_loader: directed steps plus random traffic against a frame-level queue model.
module tb_array_frame_loader;
  localparam int ROWS  = 4;
  localparam int COLS  = 2;
  localparam int WIDTH = 16;
  localparam int N     = ROWS * COLS;
  localparam int FW    = ROWS * COLS * WIDTH;
  typedef logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] in_data = '0;
  frame_t frame_out;
  logic frame_valid;
  logic frame_ack = 1'b0;
  logic [$clog2(ROWS):0] row_idx;
  logic [$clog2(COLS):0] col_idx;
  logic [7:0] frame_count;
`ifdef ARRAY_FRAME_LOADER_UNPACKED_EN
  logic [WIDTH-1:0] frame_unp [ROWS-1:0][COLS-1:0];
`endif

  array_frame_loader #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .row_idx(row_idx), .col_idx(col_idx), .frame_count(frame_count)
`ifdef ARRAY_FRAME_LOADER_UNPACKED_EN
    , .frame_unp(frame_unp)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: accepted elements queue up until a frame is complete.
  logic [WIDTH-1:0] q[$];
  frame_t m_frame, m_pframe;
  bit m_valid, m_pend;
  logic [7:0] m_count;
  int nframes = 0;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("frame_valid", FW'(frame_valid), FW'(m_valid));
    chk("frame_out", frame_out, m_frame);
    chk("frame_count", FW'(frame_count), FW'(m_count));
    chk("row_idx", FW'(row_idx), FW'(q.size() / COLS));
    chk("col_idx", FW'(col_idx), FW'(q.size() % COLS));
`ifdef ARRAY_FRAME_LOADER_UNPACKED_EN
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < COLS; k++)
        chk("frame_unp", FW'(frame_unp[i][k]), FW'(m_frame[i][k]));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; frame_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_frame = '0; m_pframe = '0; m_valid = 0; m_pend = 0; m_count = '0;
    check_outputs();
    chk("in_ready_after_reset", FW'(in_ready), FW'(1));
  endtask

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit a);
    frame_t f;
    bit pub;
    in_valid = v; in_data = d; frame_ack = a;
    chk("in_ready", FW'(in_ready), FW'(!m_pend));
    pub = 0;
    f = '0;
    if (v && !m_pend) begin
      q.push_back(d);
      if (q.size() == N) begin
        for (int n = 0; n < N; n++) f[n / COLS][n % COLS] = q[n];
        q.delete();
        if (!m_valid || a) begin m_frame = f; pub = 1; end
        else begin m_pframe = f; m_pend = 1; end
      end
    end else if (m_pend && a) begin
      m_frame = m_pframe; m_pend = 0; pub = 1;
    end
    if (pub) begin m_valid = 1; m_count = m_count + 8'd1; nframes++; end
    else if (a) m_valid = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_ack = 1'b0;
    check_outputs();
  endtask

  initial begin
    int target;
    do_reset();

    // Frame 1: d(i,k)=i+1+k, continuous valid.
    for (int n = 0; n < N; n++) step(1, WIDTH'(n / COLS + 1 + n % COLS), 0);
    chk("t1_valid", FW'(frame_valid), FW'(1));
    chk("t1_f21", FW'(frame_out[2][1]), FW'(4));
    chk("t1_f00", FW'(frame_out[0][0]), FW'(1));
    chk("t1_count", FW'(frame_count), FW'(1));

    // Frame 2 while frame 1 is held: stalls, then one ack publishes it.
    for (int n = 0; n < N; n++) step(1, WIDTH'(n / COLS + 11 + n % COLS), 0);
    chk("t2_ready_low", FW'(in_ready), FW'(0));
    chk("t2_hold_f21", FW'(frame_out[2][1]), FW'(4));
    step(1, 16'hdead, 1);
    chk("t2_f31", FW'(frame_out[3][1]), FW'(15));
    chk("t2_count", FW'(frame_count), FW'(2));
    chk("t2_ready_back", FW'(in_ready), FW'(1));

    // Last accept coinciding with ack: no bubble.
    for (int n = 0; n < N - 1; n++) step(1, WIDTH'($urandom), 0);
    step(1, 16'h7777, 1);
    chk("t3_valid", FW'(frame_valid), FW'(1));
    chk("t3_ready", FW'(in_ready), FW'(1));
    chk("t3_count", FW'(frame_count), FW'(3));
    chk("t3_f31", FW'(frame_out[3][1]), FW'(16'h7777));

    // Reset mid-frame, then a clean frame.
    for (int n = 0; n < 5; n++) step(1, WIDTH'($urandom), 0);
    chk("t4_row", FW'(row_idx), FW'(2));
    chk("t4_col", FW'(col_idx), FW'(1));
    do_reset();
    for (int n = 0; n < N; n++) step(1, WIDTH'(n / COLS + 1 + n % COLS), 0);
    chk("t4_f21", FW'(frame_out[2][1]), FW'(4));
    chk("t4_count", FW'(frame_count), FW'(1));

    // Random gaps and acks over 20 frames.
    target = nframes + 20;
    for (int cyc = 0; cyc < 4000 && nframes < target; cyc++)
      step(bit'($urandom % 2), WIDTH'($urandom), bit'($urandom % 3 == 0));
    chk("t5_frames_done", FW'(nframes >= target), FW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
